// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop sync, debounce FSM, press/release/hold pulses.
// Define BUTTON_HOLD_EN to build the long-press hold counter and btn_hold pulse.
module button_conditioner #(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int HOLD_CYCLES     = 2000000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_hold
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_e;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic          sync1_q, sync2_q;
        logic          s;
        state_e        state_q, state_d;
        logic [DW-1:0] db_q, db_d;
        logic          level_q, level_d;
        logic          press_q, press_d;
        logic          release_q, release_d;

        // Synchroniser idles at the released level so reset never looks like a press.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1_q <= ACTIVE_LOW;
                sync2_q <= ACTIVE_LOW;
            end else begin
                sync1_q <= btn_raw[i];
                sync2_q <= sync1_q;
            end
        end

        assign s = sync2_q ^ ACTIVE_LOW;

        always_comb begin
            state_d   = state_q;
            db_d      = db_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (s) begin
                        state_d = PRESS_WAIT;
                        db_d    = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state_d = IDLE;
                    end else if (db_q == DB_MAX) begin
                        state_d = PRESSED;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        db_d = db_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        state_d = RELEASE_WAIT;
                        db_d    = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        state_d = PRESSED;
                    end else if (db_q == DB_MAX) begin
                        state_d   = IDLE;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        db_d = db_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q   <= IDLE;
                db_q      <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                db_q      <= db_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;

`ifdef BUTTON_HOLD_EN
        localparam int HW = $clog2(HOLD_CYCLES);
        localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

        logic [HW-1:0] hold_cnt_q, hold_cnt_d;
        logic          fired_q, fired_d;
        logic          hold_q, hold_d;

        // The counter spans the whole press, including release bounces.
        always_comb begin
            hold_cnt_d = hold_cnt_q;
            fired_d    = fired_q;
            hold_d     = 1'b0;
            unique case (state_q)
                PRESS_WAIT: begin
                    if (state_d == PRESSED) begin
                        hold_cnt_d = '0;
                        fired_d    = 1'b0;
                    end
                end
                PRESSED: begin
                    if (hold_cnt_q != HOLD_MAX) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                    if (hold_cnt_q == HOLD_MAX && !fired_q) begin
                        hold_d  = 1'b1;
                        fired_d = 1'b1;
                    end
                end
                RELEASE_WAIT: begin
                    if (hold_cnt_q != HOLD_MAX) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hold_cnt_q <= '0;
                fired_q    <= 1'b0;
                hold_q     <= 1'b0;
            end else begin
                hold_cnt_q <= hold_cnt_d;
                fired_q    <= fired_d;
                hold_q     <= hold_d;
            end
        end

        assign btn_hold[i] = hold_q;
`else
        assign btn_hold[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised bench for button_conditioner against an edge-indexed reference model.
// Hold expectations follow BUTTON_HOLD_EN as defined for the build.
module tb_button_conditioner;

    localparam int NB = 2;
    localparam int D  = 4;
    localparam int H  = 10;
`ifdef BUTTON_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level, btn_press, btn_release, btn_hold;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BTN(NB),
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES(H),
        .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release),
        .btn_hold(btn_hold)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: s at edge n is raw sampled at edge n-2; a level is
    // accepted once the last D+1 samples of s all disagree with it.
    logic [NB-1:0] m_d1, m_d2, s_prev;
    logic [D:0]    hist [NB];
    logic [NB-1:0] m_level, m_press, m_rel, m_hold;
    int            m_n;
    int            p_edge [NB];
    bit            fired [NB];

    task automatic model_reset();
        m_d1 = '0; m_d2 = '0; s_prev = '0;
        m_level = '0; m_press = '0; m_rel = '0; m_hold = '0;
        m_n = 0;
        for (int c = 0; c < NB; c++) begin
            hist[c]   = '0;
            p_edge[c] = 0;
            fired[c]  = 1'b0;
        end
    endtask

    task automatic model_step(input logic [NB-1:0] raw);
        logic [NB-1:0] s_now;
        s_now = m_d2;
        m_d2  = m_d1;
        m_d1  = raw;
        m_n++;
        for (int c = 0; c < NB; c++) begin
            m_hold[c] = HOLD_EN && m_level[c] && s_prev[c] &&
                        (m_n - p_edge[c] >= H) && !fired[c];
            if (m_hold[c]) fired[c] = 1'b1;
            hist[c]    = {hist[c][D-1:0], s_now[c]};
            m_press[c] = 1'b0;
            m_rel[c]   = 1'b0;
            if (!m_level[c] && (&hist[c])) begin
                m_level[c] = 1'b1;
                m_press[c] = 1'b1;
                p_edge[c]  = m_n;
                fired[c]   = 1'b0;
            end else if (m_level[c] && !(|hist[c])) begin
                m_level[c] = 1'b0;
                m_rel[c]   = 1'b1;
            end
        end
        s_prev = s_now;
    endtask

    task automatic step(input logic [NB-1:0] raw);
        btn_raw = raw;
        @(posedge clk);
        #1;
        model_step(raw);
        check("level", btn_level, m_level);
        check("press", btn_press, m_press);
        check("release", btn_release, m_rel);
        check("hold", btn_hold, m_hold);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_level"}, btn_level, 0);
        check({tag, "_press"}, btn_press, 0);
        check({tag, "_release"}, btn_release, 0);
        check({tag, "_hold"}, btn_hold, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_zero("rst_async");
        model_reset();
        @(posedge clk);
        #1;
        check_zero("rst_held");
        @(negedge clk);
        rst = 1'b0;
    endtask

    int pe, he, hc, rc, re, drop, pc, pv;
    logic [NB-1:0] cur;
    int left [NB];

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        for (int e = 0; e < 3; e++) step(2'b00);

        // Clean press on ch0, long hold
        pe = -1; he = -1; hc = 0; drop = 0;
        for (int e = 0; e < 40; e++) begin
            step(2'b01);
            if (btn_press[0]) pe = e;
            if (btn_hold[0]) begin he = e; hc++; end
            if (e >= 6 && !btn_level[0]) drop++;
        end
        check("clean_press_edge", pe, 6);
        check("clean_level_held", drop, 0);
`ifdef BUTTON_HOLD_EN
        check("clean_hold_edge", he, 16);
        check("clean_hold_count", hc, 1);
`else
        check("clean_hold_count", hc, 0);
`endif

        // Release bounce on ch0
        rc = 0; drop = 0;
        for (int e = 0; e < 3; e++) begin
            step(2'b00);
            if (btn_release[0]) rc++;
            if (!btn_level[0]) drop++;
        end
        for (int e = 0; e < 8; e++) begin
            step(2'b01);
            if (btn_release[0]) rc++;
            if (!btn_level[0]) drop++;
        end
        check("bounce_release", rc, 0);
        check("bounce_level", drop, 0);
        re = -1;
        for (int e = 0; e < 12; e++) begin
            step(2'b00);
            if (btn_release[0]) re = e;
        end
        check("release_edge", re, 6);

        // Glitch rejection on ch1: 4 high rejected, 5 high accepted
        pc = 0; drop = 0;
        for (int e = 0; e < 4; e++) begin
            step(2'b10);
            if (btn_press[1]) pc++;
            if (btn_level[1]) drop++;
        end
        for (int e = 0; e < 10; e++) begin
            step(2'b00);
            if (btn_press[1]) pc++;
            if (btn_level[1]) drop++;
        end
        check("glitch_press", pc, 0);
        check("glitch_level", drop, 0);
        pe = -1; re = -1;
        for (int e = 0; e < 15; e++) begin
            step(e < 5 ? 2'b10 : 2'b00);
            if (btn_press[1]) pe = e;
            if (btn_release[1]) re = e;
        end
        check("glitch5_press_edge", pe, 6);
        check("glitch5_release_edge", re, 11);

        // Simultaneous press on both channels
        pe = -1; pc = 0; pv = 0;
        for (int e = 0; e < 10; e++) begin
            step(2'b11);
            if (btn_press != 0) begin pc++; pe = e; pv = btn_press; end
        end
        check("simul_press_edge", pe, 6);
        check("simul_press_val", pv, 3);
        check("simul_press_width", pc, 1);
        for (int e = 0; e < 12; e++) step(2'b00);

        // Reset while ch0 is pressed, button held through reset
        for (int e = 0; e < 10; e++) step(2'b01);
        check("pre_reset_level", btn_level, 2'b01);
        do_reset();
        pe = -1; rc = 0;
        for (int e = 0; e < 10; e++) begin
            step(2'b01);
            if (btn_press[0]) pe = e;
            if (btn_release[0]) rc++;
        end
        check("post_reset_press_edge", pe, 6);
        check("post_reset_release", rc, 0);
        for (int e = 0; e < 12; e++) step(2'b00);

        // Randomised bursts against the model
        cur = '0;
        for (int c = 0; c < NB; c++) left[c] = 0;
        for (int k = 0; k < 4000; k++) begin
            for (int c = 0; c < NB; c++) begin
                if (left[c] == 0) begin
                    cur[c]  = ~cur[c];
                    left[c] = ($urandom_range(0, 3) == 0) ?
                              $urandom_range(1, 25) : $urandom_range(1, 8);
                end
                left[c]--;
            end
            if ($urandom_range(0, 799) == 0) do_reset();
            step(cur);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Input-side conditioner for the reaction-time tester's push-buttons (start, response), feeding the delay and count blocks with clean signals. It synchronises each raw button to `clk`, debounces it with a per-channel state machine and produces a stable level, single-cycle press and release pulses, and an optional long-press pulse. It sits between the board pins and the control logic in `top_control`.

## Interface
- `N_BTN`, 2: number of independent button channels.
- `DEBOUNCE_CYCLES`, 20000: consecutive stable cycles required to accept a level change; legal values ≥ 2.
- `HOLD_CYCLES`, 2000000: cycles in PRESSED before `btn_hold` fires; legal values ≥ 2.
- `ACTIVE_LOW`, 0: 1 means a raw 0 is "pressed".
- `clk` in 1: system clock, all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `btn_raw` in N_BTN: raw, asynchronous button inputs.
- `btn_level` out N_BTN: debounced pressed level; 1 = pressed.
- `btn_press` out N_BTN: one-cycle pulse on an accepted press.
- `btn_release` out N_BTN: one-cycle pulse on an accepted release.
- `btn_hold` out N_BTN: one-cycle pulse, at most once per press, after a long press.

## Operation
- Each channel is independent, with no shared counters.
- Per-channel path: 2-flop synchroniser, then polarity normalisation (`ACTIVE_LOW`), giving the signal `s`. `s` feeds a 4-state FSM.
- **IDLE** (level 0):
  - `s`=1 → PRESS_WAIT, and the debounce counter is cleared to 0.
- **PRESS_WAIT**:
  - `s`=0 → IDLE; no output activity.
  - `s`=1 and count < D-1 → count+1.
  - `s`=1 and count == D-1 → PRESSED. On that edge `btn_level` goes to 1, `btn_press` pulses, and the hold counter is cleared.
- **PRESSED**:
  - The hold counter increments each cycle and saturates at H-1.
  - On reaching H-1, `btn_hold` pulses once.
  - `s`=0 → RELEASE_WAIT, and the debounce counter is cleared.
- **RELEASE_WAIT**:
  - `s`=1 → PRESSED. The hold counter is not cleared, and `btn_hold` is not re-issued if it was already issued for this press.
  - `s`=0 and count == D-1 → IDLE. On that edge `btn_level` goes to 0 and `btn_release` pulses.
  - The hold counter keeps counting in this state.
- Counter widths: `$clog2(DEBOUNCE_CYCLES)` and `$clog2(HOLD_CYCLES)`, with no wrap-around (saturating).
- Simultaneous presses on several channels are handled independently in the same cycle.
- Reset:
  - All outputs are 0, all FSMs are IDLE, all counters are 0.
  - Synchroniser flops reset to the released level.
  - Reset asserted mid-press drops `btn_level` immediately and does not emit `btn_release`.
  - A button still held when reset deasserts is accepted as a new press after the normal debounce.

## Timing
- All outputs are registered. Reset values are `btn_level`=0, `btn_press`=0, `btn_release`=0, `btn_hold`=0.
- Edge 0 is the first rising edge that samples a new raw level. D = `DEBOUNCE_CYCLES`, H = `HOLD_CYCLES`.
- Press: `btn_level` rises and `btn_press` is high for exactly one cycle, both after edge D+2.
- Release: same latency, measured from the first edge sampling the released level.
- Glitch filter: a raw level lasting D cycles or fewer is rejected; D+1 cycles or more is accepted.
- Hold: `btn_hold` is high for one cycle after edge D+2+H, for a continuously held button.
- `btn_press` and `btn_release` never assert in the same cycle on one channel. The minimum spacing between them is D+1 cycles.

## Configuration
- `BUTTON_HOLD_EN`:
  - Defined: the hold counter and `btn_hold` are implemented as above.
  - Undefined: the hold counter logic is not synthesised, `btn_hold` is tied to 0, and `HOLD_CYCLES` is ignored.

## Test plan
Bench configuration: `N_BTN`=2, `DEBOUNCE_CYCLES`=4, `HOLD_CYCLES`=10, `ACTIVE_LOW`=0, `BUTTON_HOLD_EN` defined.
- Clean press: ch0 raw 0→1, held 30 cycles → `btn_press[0]` is one cycle after edge 6, `btn_level[0]`=1 from the same edge, `btn_hold[0]` is one cycle after edge 16, with no second hold pulse.
- Glitch rejection: ch1 raw high for 4 cycles, then low → no `btn_press`, `btn_level[1]` stays 0. Repeat with 5 cycles high → press accepted after edge 6, then release accepted.
- Release bounce: during PRESSED, raw low for 3 cycles then high → no `btn_release`, `btn_level` stays 1. Raw low for 5+ cycles → `btn_release` one cycle after edge 6 of the low level.
- Simultaneous channels: both raw rise on the same edge → `btn_press`=2'b11 in the same cycle, one cycle wide.
- Reset mid-operation: assert `rst` while ch0 is PRESSED → all outputs 0 immediately, no `btn_release`. Deassert `rst` with raw still high → `btn_press[0]` fires after edge 6, counting from the first post-reset sample.
- Macro off (rebuild without `BUTTON_HOLD_EN`): hold ch0 for 40 cycles → `btn_hold` is always 0; press and release timing is unchanged.
